// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and big-endian lane select.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2
    } lsuState_e;

    // Bit position of the lane's LSB inside the word; byte offset 0 is the most significant lane.
    function automatic logic [4:0] laneShift(input logic [1:0] size, input logic [1:0] offset);
        logic [4:0] shift;
        shift = 5'd0;
        case (size)
            SZ_BYTE: shift = {~offset, 3'b000};
            SZ_HALF: shift = {~offset[1], 4'b0000};
            default: shift = 5'd0;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Lane steering: extracts and extends a load lane, and splices store data into a read word.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        isUnsigned,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedData
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shift   = laneShift(size, offset);
        shifted = word >> shift;
        case (size)
            SZ_BYTE: begin
                loadData = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
                mask     = 32'h0000_00ff << shift;
            end
            SZ_HALF: begin
                loadData = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
                mask     = 32'h0000_ffff << shift;
            end
            default: begin
                loadData = word;
                mask     = 32'hffff_ffff;
            end
        endcase
        mergedData = (word & ~mask) | ((storeData << shift) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    output logic              stall,
    output logic              memWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              wb_misaligned
);

    lsuState_e         state;
    logic              reqMemRead, reqMemWrite, reqUnsigned, reqRegWrite, reqMisaligned;
    logic [1:0]        reqSize, reqOffset;
    logic [ADDR_W-1:0] reqAddress;
    logic [DATA_W-1:0] reqStoreData, mergeBuf;
    logic [4:0]        reqRd;

    logic              inMisaligned;
    logic [1:0]        inOffset;
    logic              accept, reqLoad, reqWordStore, reqSubStore;
    logic [DATA_W-1:0] laneWord, loadData, mergedData;

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        inOffset     = in_address[1:0];
        inMisaligned = (in_mem_read || in_mem_write) &&
                       ((in_size == SZ_HALF && in_address[0]) ||
                        (in_size == SZ_WORD && in_address[1:0] != 2'b00));
`else
        inMisaligned = 1'b0;
        case (in_size)
            SZ_BYTE: inOffset = in_address[1:0];
            SZ_HALF: inOffset = {in_address[1], 1'b0};
            default: inOffset = 2'b00;
        endcase
`endif
    end

    // A flagged misaligned request behaves like a bubble on the memory port.
    assign reqLoad      = reqMemRead && !reqMisaligned;
    assign reqWordStore = reqMemWrite && !reqMisaligned && !(reqSize == SZ_BYTE || reqSize == SZ_HALF);
    assign reqSubStore  = reqMemWrite && !reqMisaligned && (reqSize == SZ_BYTE || reqSize == SZ_HALF);

    assign stall          = (state == ST_ACCESS) && reqSubStore;
    assign accept         = in_valid && !stall;
    assign memWrite       = ((state == ST_ACCESS) && reqWordStore) || (state == ST_MERGE);
    assign mem_address    = {reqAddress[ADDR_W-1:2], 2'b00};
    assign mem_write_data = (state == ST_MERGE) ? mergedData : reqStoreData;
    assign laneWord       = (state == ST_MERGE) ? mergeBuf : mem_read_data;

    lsu_lane_mux u_laneMux (
        .word       (laneWord),
        .size       (reqSize),
        .offset     (reqOffset),
        .isUnsigned (reqUnsigned),
        .storeData  (reqStoreData),
        .loadData   (loadData),
        .mergedData (mergedData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            reqMemRead    <= 1'b0;
            reqMemWrite   <= 1'b0;
            reqUnsigned   <= 1'b0;
            reqRegWrite   <= 1'b0;
            reqMisaligned <= 1'b0;
            reqSize       <= 2'b00;
            reqOffset     <= 2'b00;
            reqAddress    <= '0;
            reqStoreData  <= '0;
            reqRd         <= 5'd0;
            mergeBuf      <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= 5'd0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
        end else begin
            if (accept) begin
                reqMemRead    <= in_mem_read;
                reqMemWrite   <= in_mem_write;
                reqUnsigned   <= in_unsigned;
                reqRegWrite   <= in_reg_write;
                reqMisaligned <= inMisaligned;
                reqSize       <= in_size;
                reqOffset     <= inOffset;
                reqAddress    <= in_address;
                reqStoreData  <= in_store_data;
                reqRd         <= in_rd;
            end
            if (state == ST_ACCESS && reqSubStore) begin
                mergeBuf <= mem_read_data;
            end

            // Every request retires to WB at the end of its ACCESS cycle, stores included.
            wb_valid <= (state == ST_ACCESS);
            if (state == ST_ACCESS) begin
                wb_rd         <= reqRd;
                wb_misaligned <= reqMisaligned;
                wb_reg_write  <= reqRegWrite && !reqMemWrite && !reqMisaligned;
                if (reqLoad) begin
                    wb_data <= loadData;
                end else if (reqMemRead || reqMemWrite) begin
                    wb_data <= '0;
                end else begin
                    wb_data <= DATA_W'(reqAddress);
                end
            end

            case (state)
                ST_IDLE:   state <= accept ? ST_ACCESS : ST_IDLE;
                ST_ACCESS: begin
                    if (reqSubStore) begin
                        state <= ST_MERGE;
                    end else begin
                        state <= accept ? ST_ACCESS : ST_IDLE;
                    end
                end
                ST_MERGE:  state <= accept ? ST_ACCESS : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word-wide memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_mem_read, in_mem_write, in_unsigned, in_reg_write;
    logic [1:0]  in_size;
    logic [31:0] in_address, in_store_data;
    logic [4:0]  in_rd;
    logic        stall, memWrite, wb_valid, wb_reg_write, wb_misaligned;
    logic [31:0] mem_address, mem_write_data, mem_read_data, wb_data;
    logic [4:0]  wb_rd;

    logic [31:0] mem [0:31];
    logic        preloadEn = 1'b0;
    logic [4:0]  preloadIdx = 5'd0;
    logic [31:0] preloadVal = 32'd0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[6:2]];

    always @(posedge clk) begin
        if (preloadEn) mem[preloadIdx] <= preloadVal;
        else if (memWrite) mem[mem_address[6:2]] <= mem_write_data;
    end

    load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .in_address     (in_address),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .stall          (stall),
        .memWrite       (memWrite),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_misaligned  (wb_misaligned)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] dst, input logic rw);
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_size = sz;
        in_unsigned = uns; in_address = addr; in_store_data = data; in_rd = dst;
        in_reg_write = rw;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_size = 2'b00;
        in_unsigned = 1'b0; in_address = 32'd0; in_store_data = 32'd0; in_rd = 5'd0;
        in_reg_write = 1'b0;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        preloadEn = 1'b1; preloadIdx = addr[6:2]; preloadVal = val;
        step();
        preloadEn = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
        total++; if (memWrite !== 1'b0) $display("FAIL reset_memWrite got %b want 0", memWrite); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else passed++;
        total++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data got %h want 0", wb_data); else passed++;
        total++; if (mem_address !== 32'd0) $display("FAIL reset_addr got %h want 0", mem_address); else passed++;
        total++; if (wb_misaligned !== 1'b0) $display("FAIL reset_mis got %b want 0", wb_misaligned); else passed++;
        #2 reset = 1'b0;
        step();
    endtask

    task automatic test_word_store_load();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h7fff_ffe0, 32'h0000_0005, 5'd0, 1'b0);
        step();
        idle();
        total++; if (memWrite !== 1'b1) $display("FAIL sw_memWrite got %b want 1", memWrite); else passed++;
        total++; if (mem_address !== 32'h7fff_ffe0) $display("FAIL sw_addr got %h want 7fffffe0", mem_address); else passed++;
        total++; if (mem_write_data !== 32'h5) $display("FAIL sw_data got %h want 00000005", mem_write_data); else passed++;
        step();
        total++; if (memWrite !== 1'b0) $display("FAIL sw_one_cycle got %b want 0", memWrite); else passed++;
        total++; if (wb_valid !== 1'b1) $display("FAIL sw_wb_valid got %b want 1", wb_valid); else passed++;
        total++; if (wb_reg_write !== 1'b0) $display("FAIL sw_wb_rw got %b want 0", wb_reg_write); else passed++;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h7fff_ffe0, 32'd0, 5'd3, 1'b1);
        step();
        idle();
        total++; if (wb_valid !== 1'b0) $display("FAIL lw_wb_early got %b want 0", wb_valid); else passed++;
        step();
        total++; if (wb_valid !== 1'b1) $display("FAIL lw_wb_valid got %b want 1", wb_valid); else passed++;
        total++; if (wb_data !== 32'h5) $display("FAIL lw_data got %h want 00000005", wb_data); else passed++;
        total++; if (wb_rd !== 5'd3) $display("FAIL lw_rd got %0d want 3", wb_rd); else passed++;
        total++; if (wb_reg_write !== 1'b1) $display("FAIL lw_rw got %b want 1", wb_reg_write); else passed++;
    endtask

    task automatic test_byte_load();
        preload(32'h7fff_fff0, 32'hfff3_e779);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h7fff_fff1, 32'd0, 5'd4, 1'b1);
        step();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h7fff_fff1, 32'd0, 5'd5, 1'b1);
        step();
        total++; if (wb_data !== 32'hffff_fff3) $display("FAIL lb got %h want fffffff3", wb_data); else passed++;
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h7fff_fff2, 32'd0, 5'd6, 1'b1);
        step();
        total++; if (wb_data !== 32'h0000_00f3) $display("FAIL lbu got %h want 000000f3", wb_data); else passed++;
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h7fff_fff0, 32'd0, 5'd7, 1'b1);
        step();
        total++; if (wb_data !== 32'hffff_e779) $display("FAIL lh got %h want ffffe779", wb_data); else passed++;
        total++; if (wb_rd !== 5'd6) $display("FAIL lh_rd got %0d want 6", wb_rd); else passed++;
        idle();
        step();
        total++; if (wb_data !== 32'h0000_fff3) $display("FAIL lhu got %h want 0000fff3", wb_data); else passed++;
        step();
    endtask

    task automatic test_rmw_store();
        preload(32'h7fff_ffa0, 32'h1122_3344);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h7fff_ffa2, 32'h0000_00ab, 5'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h7fff_ffa0, 32'd0, 5'd8, 1'b1);
        total++; if (stall !== 1'b1) $display("FAIL rmw_stall got %b want 1", stall); else passed++;
        total++; if (memWrite !== 1'b0) $display("FAIL rmw_read_phase got %b want 0", memWrite); else passed++;
        step();
        total++; if (stall !== 1'b0) $display("FAIL rmw_stall_drop got %b want 0", stall); else passed++;
        total++; if (memWrite !== 1'b1) $display("FAIL rmw_write got %b want 1", memWrite); else passed++;
        total++; if (mem_write_data !== 32'h1122_ab44) $display("FAIL rmw_data got %h want 1122ab44", mem_write_data); else passed++;
        total++; if (mem_address !== 32'h7fff_ffa0) $display("FAIL rmw_addr got %h want 7fffffa0", mem_address); else passed++;
        total++; if (wb_valid !== 1'b1) $display("FAIL rmw_wb_valid got %b want 1", wb_valid); else passed++;
        step();
        idle();
        total++; if (memWrite !== 1'b0) $display("FAIL rmw_after got %b want 0", memWrite); else passed++;
        step();
        total++; if (wb_data !== 32'h1122_ab44) $display("FAIL rmw_lw got %h want 1122ab44", wb_data); else passed++;
        total++; if (wb_rd !== 5'd8) $display("FAIL rmw_lw_rd got %0d want 8", wb_rd); else passed++;
        step();
    endtask

    task automatic test_reset_merge();
        preload(32'h7fff_ffc0, 32'hdead_beef);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h7fff_ffc0, 32'h0000_1234, 5'd0, 1'b0);
        step();
        idle();
        step();
        total++; if (memWrite !== 1'b1) $display("FAIL merge_pre got %b want 1", memWrite); else passed++;
        total++; if (mem_write_data !== 32'h1234_beef) $display("FAIL merge_data got %h want 1234beef", mem_write_data); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (memWrite !== 1'b0) $display("FAIL rst_memWrite got %b want 0", memWrite); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b want 0", wb_valid); else passed++;
        step();
        reset = 1'b0;
        step();
        total++; if (memWrite !== 1'b0) $display("FAIL rst_no_retry got %b want 0", memWrite); else passed++;
        step();
        total++; if (mem[16] !== 32'hdead_beef) $display("FAIL rst_mem got %h want deadbeef", mem[16]); else passed++;
    endtask

    task automatic test_misaligned();
        preload(32'h7fff_ffe0, 32'h89ab_cdef);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h7fff_ffe2, 32'd0, 5'd9, 1'b1);
        step();
        idle();
        total++; if (memWrite !== 1'b0) $display("FAIL mis_memWrite got %b want 0", memWrite); else passed++;
        step();
        total++; if (wb_valid !== 1'b1) $display("FAIL mis_wb_valid got %b want 1", wb_valid); else passed++;
`ifdef LSU_MISALIGN_TRAP_EN
        total++; if (wb_misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", wb_misaligned); else passed++;
        total++; if (wb_reg_write !== 1'b0) $display("FAIL mis_rw got %b want 0", wb_reg_write); else passed++;
`else
        total++; if (wb_misaligned !== 1'b0) $display("FAIL mis_flag got %b want 0", wb_misaligned); else passed++;
        total++; if (wb_data !== 32'h89ab_cdef) $display("FAIL mis_align got %h want 89abcdef", wb_data); else passed++;
        total++; if (wb_reg_write !== 1'b1) $display("FAIL mis_rw got %b want 1", wb_reg_write); else passed++;
`endif
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h7fff_ffe0, 32'd0, 5'd11, 1'b1);
        step();
        total++; if (stall !== 1'b0) $display("FAIL b2b_stall1 got %b want 0", stall); else passed++;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h7fff_ff80, 32'h5566_7788, 5'd0, 1'b0);
        step();
        total++; if (stall !== 1'b0) $display("FAIL b2b_stall2 got %b want 0", stall); else passed++;
        total++; if (wb_data !== 32'h89ab_cdef) $display("FAIL b2b_lw got %h want 89abcdef", wb_data); else passed++;
        total++; if (wb_rd !== 5'd11) $display("FAIL b2b_lw_rd got %0d want 11", wb_rd); else passed++;
        total++; if (memWrite !== 1'b1) $display("FAIL b2b_sw got %b want 1", memWrite); else passed++;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h7fff_fff3, 32'd0, 5'd12, 1'b1);
        step();
        total++; if (stall !== 1'b0) $display("FAIL b2b_stall3 got %b want 0", stall); else passed++;
        total++; if (wb_valid !== 1'b1) $display("FAIL b2b_sw_wb got %b want 1", wb_valid); else passed++;
        total++; if (wb_reg_write !== 1'b0) $display("FAIL b2b_sw_rw got %b want 0", wb_reg_write); else passed++;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'd0, 5'd13, 1'b1);
        step();
        total++; if (memWrite !== 1'b0) $display("FAIL b2b_nomem got %b want 0", memWrite); else passed++;
        total++; if (wb_data !== 32'h0000_0079) $display("FAIL b2b_lb got %h want 00000079", wb_data); else passed++;
        total++; if (wb_rd !== 5'd12) $display("FAIL b2b_lb_rd got %0d want 12", wb_rd); else passed++;
        idle();
        step();
        total++; if (wb_data !== 32'h0000_1234) $display("FAIL b2b_alu got %h want 00001234", wb_data); else passed++;
        total++; if (wb_reg_write !== 1'b1) $display("FAIL b2b_alu_rw got %b want 1", wb_reg_write); else passed++;
        step();
        total++; if (wb_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", wb_valid); else passed++;
        total++; if (mem[0] !== 32'h5566_7788) $display("FAIL b2b_mem got %h want 55667788", mem[0]); else passed++;
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_load();
        test_rmw_store();
        test_reset_merge();
        test_misaligned();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
